alu_muldiv_unit: RTL and testbench

- Parametrised multi-cycle successor to the combinational ALU control decode. Decodes RV32M (opcode ARITHMETIC, funct7 = 0000001) from opcode/funct7/funct3 and executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the main ALU in EX.
- Uses a valid/ready handshake so the hazard unit can stall the pipeline while it is busy.

---
 rtl/alu_muldiv_unit_if.sv | 31 +++
 rtl/alu_muldiv_unit.sv | 127 ++++++++++++
 tb/tb_alu_muldiv_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_unit_if.sv
// Request/response bundle between EX issue logic and the RV32M multiply/divide unit.
interface alu_muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic [6:0]       opcode;
  logic [6:0]       funct7;
  logic [2:0]       funct3;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [TAG_W-1:0] tag_in;
  logic             flush;
  logic             is_md;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output opcode, funct7, funct3, in_valid, rs1_data, rs2_data, tag_in, flush, out_ready,
    input  in_ready, is_md, busy, out_valid, result, tag_out
  );

  modport slave (
    input  opcode, funct7, funct3, in_valid, rs1_data, rs2_data, tag_in, flush, out_ready,
    output in_ready, is_md, busy, out_valid, result, tag_out
  );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Multi-cycle RV32M unit: restoring divide and shift-add (or single-cycle) multiply on
// operand magnitudes, with the sign applied as the result is written.
module alu_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 1,
  parameter int TAG_W    = 5
) (
  input logic               clk,
  input logic               reset,
  alu_muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [6:0] OP_ARITH = 7'b0110011;
  localparam logic [6:0] F7_MD    = 7'b0000001;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [2:0]         f3;
  logic [TAG_W-1:0]   tag;
  logic [XLEN-1:0]    op_a, op_b;
  logic               neg;
  logic [2*XLEN-1:0]  acc;
  logic [CW-1:0]      cnt;
  logic [XLEN-1:0]    result;
  logic [TAG_W-1:0]   tag_out;

  assign bus.is_md     = (bus.opcode == OP_ARITH) && (bus.funct7 == F7_MD);
  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result;
  assign bus.tag_out   = tag_out;

  logic accept;
  assign accept = bus.in_valid & bus.in_ready & bus.is_md & ~bus.flush;

  // Accept-side decode: magnitudes, result sign and the early-exit cases.
  logic            is_div, sgn_a, sgn_b, div_zero, ovf;
  logic [XLEN-1:0] abs_a, abs_b;
  always_comb begin
    is_div   = bus.funct3[2];
    sgn_a    = (bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110}) && bus.rs1_data[XLEN-1];
    sgn_b    = (bus.funct3 inside {3'b001, 3'b100, 3'b110}) && bus.rs2_data[XLEN-1];
    abs_a    = sgn_a ? -bus.rs1_data : bus.rs1_data;
    abs_b    = sgn_b ? -bus.rs2_data : bus.rs2_data;
    div_zero = is_div && (bus.rs2_data == '0);
    ovf      = is_div && !bus.funct3[0] && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
               && (&bus.rs2_data);
  end

  // acc holds {remainder, quotient} for divide and {partial product, multiplier} for multiply.
  logic [XLEN:0]      trial, diff, sum;
  logic [2*XLEN-1:0]  acc_nxt, prod;
  logic [XLEN-1:0]    fin;
  always_comb begin
    trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff  = trial - {1'b0, op_b};
    sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_a} : {(XLEN+1){1'b0}});
    if (f3[2])
      acc_nxt = diff[XLEN] ? {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    else if (FAST_MUL != 0)
      acc_nxt = {{XLEN{1'b0}}, op_a} * {{XLEN{1'b0}}, op_b};
    else
      acc_nxt = {sum, acc[XLEN-1:1]};
    prod = neg ? -acc_nxt : acc_nxt;
    case (f3)
      3'b000:                 fin = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin = neg ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
      default:                fin = neg ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      result  <= '0;
      tag_out <= '0;
      f3      <= '0;
      tag     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      neg     <= 1'b0;
      acc     <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (accept) begin
          f3   <= bus.funct3;
          tag  <= bus.tag_in;
          op_a <= abs_a;
          op_b <= abs_b;
          // REM follows the dividend; everything else is the XOR of operand signs.
          neg  <= (is_div && bus.funct3[1]) ? sgn_a : (sgn_a ^ sgn_b);
          acc  <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
          cnt  <= (is_div || FAST_MUL == 0) ? CW'(XLEN-1) : '0;
          if (div_zero) begin
            result  <= bus.funct3[1] ? bus.rs1_data : '1;
            tag_out <= bus.tag_in;
            state   <= DONE;
          end else if (ovf) begin
            result  <= bus.funct3[1] ? '0 : bus.rs1_data;
            tag_out <= bus.tag_in;
            state   <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result  <= fin;
            tag_out <= tag;
            state   <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Vector table plus scoreboard bench for alu_muldiv_unit (32-bit fast and 16-bit iterative).
module tb_alu_muldiv_unit;
  localparam logic [6:0] OP_AR = 7'b0110011;
  localparam logic [6:0] F7_M  = 7'b0000001;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_muldiv_unit_if #(.XLEN(32), .TAG_W(5)) bus();
  alu_muldiv_unit_if #(.XLEN(16), .TAG_W(5)) bus16();

  alu_muldiv_unit #(.XLEN(32), .FAST_MUL(1), .TAG_W(5)) dut   (.clk(clk), .reset(reset), .bus(bus));
  alu_muldiv_unit #(.XLEN(16), .FAST_MUL(0), .TAG_W(5)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[16];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one M op on the 32-bit unit, track it through the scoreboard, optionally stall the consumer.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp, input int lat,
                       input int hold, input string name);
    int  cyc;
    sb_t e;
    bus.opcode = OP_AR; bus.funct7 = F7_M; bus.funct3 = f3;
    bus.rs1_data = a; bus.rs2_data = b; bus.tag_in = tag; bus.in_valid = 1'b1;
    e.res = exp; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.rs1_data = $urandom; bus.rs2_data = $urandom; bus.tag_in = 5'($urandom);
    cyc = 1;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, 64'(cyc), 64'(lat));
    if (bus.out_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({name, " result"}, 64'(bus.result), 64'(e.res));
      check({name, " tag"}, 64'(bus.tag_out), 64'(e.tag));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({name, " hold valid/ready"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b10);
        check({name, " hold data"}, {27'd0, bus.tag_out, bus.result}, {27'd0, e.tag, e.res});
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({name, " release"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    end else begin
      sb_q.delete();
    end
  endtask

  initial begin
    int cyc;
    logic ov_seen;
    logic [2:0]  f16 [2];
    logic [15:0] a16 [2];
    logic [15:0] b16 [2];
    logic [15:0] e16 [2];

    bus.opcode = '0; bus.funct7 = '0; bus.funct3 = '0; bus.in_valid = 1'b0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.tag_in = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus16.opcode = '0; bus16.funct7 = '0; bus16.funct3 = '0; bus16.in_valid = 1'b0;
    bus16.rs1_data = '0; bus16.rs2_data = '0; bus16.tag_in = '0; bus16.flush = 1'b0; bus16.out_ready = 1'b0;

    vecs = '{
      '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 2},
      '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 2},
      '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, 2},
      '{3'b001, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000, 2},
      '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 2},
      '{3'b000, 32'hFFFFFFFB, 32'hFFFFFFFB, 5'd6,  32'd25,       2},
      '{3'b100, 32'hFFFFFFEC, 32'd3,        5'd7,  32'hFFFFFFFA, 33},
      '{3'b110, 32'hFFFFFFEC, 32'd3,        5'd8,  32'hFFFFFFFE, 33},
      '{3'b101, 32'd100,      32'd7,        5'd10, 32'd14,       33},
      '{3'b111, 32'd100,      32'd7,        5'd11, 32'd2,        33},
      '{3'b100, 32'd7,        32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, 33},
      '{3'b110, 32'd7,        32'hFFFFFFFE, 5'd13, 32'd1,        33},
      '{3'b101, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1},
      '{3'b110, 32'd5,        32'd0,        5'd15, 32'd5,        1},
      '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1},
      '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        1}
    };

    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {25'd0, bus.out_valid, bus.busy, bus.tag_out, bus.result}, 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("in_ready after reset", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 16; i++)
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, vecs[i].lat, 0,
            $sformatf("vec%0d", i));

    // Consumer stall: DONE must hold everything steady.
    issue(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 33, 4, "stall");

    // Flush partway through a divide.
    bus.opcode = OP_AR; bus.funct7 = F7_M; bus.funct3 = 3'b100;
    bus.rs1_data = 32'd1000; bus.rs2_data = 32'd3; bus.tag_in = 5'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    ov_seen = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      if (bus.out_valid) ov_seen = 1'b1;
    end
    check("flush busy before", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush idle", {62'd0, bus.busy, bus.in_ready}, 64'b01);
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) ov_seen = 1'b1;
    end
    check("flush no out_valid", 64'(ov_seen), 64'd0);
    check("flush tag kept", 64'(bus.tag_out), 64'd9);

    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush beats accept", {62'd0, bus.busy, bus.in_ready}, 64'b01);

    // Asynchronous reset mid-divide.
    bus.funct3 = 3'b101; bus.rs1_data = 32'd12345; bus.rs2_data = 32'd7; bus.tag_in = 5'd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("mid-op busy", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    check("async reset outputs", {25'd0, bus.out_valid, bus.busy, bus.tag_out, bus.result}, 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("in_ready after mid reset", 64'(bus.in_ready), 64'd1);

    // Non-M encoding is ignored.
    bus.funct7 = 7'b0000000; bus.funct3 = 3'b000; bus.in_valid = 1'b1;
    #1;
    check("add is_md", 64'(bus.is_md), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("add ignored", {62'd0, bus.busy, bus.in_ready}, 64'b01);

    // Iterative 16-bit multiplier.
    f16[0] = 3'b010; a16[0] = 16'hFFFF; b16[0] = 16'h0002; e16[0] = 16'hFFFF;
    f16[1] = 3'b000; a16[1] = 16'h1234; b16[1] = 16'h0010; e16[1] = 16'h2340;
    for (int k = 0; k < 2; k++) begin
      bus16.opcode = OP_AR; bus16.funct7 = F7_M; bus16.funct3 = f16[k];
      bus16.rs1_data = a16[k]; bus16.rs2_data = b16[k]; bus16.tag_in = 5'(k + 4);
      bus16.in_valid = 1'b1;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0; bus16.rs1_data = 16'($urandom); bus16.rs2_data = 16'($urandom);
      cyc = 1;
      while (!bus16.out_valid && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      check($sformatf("mul16_%0d latency", k), 64'(cyc), 64'd17);
      check($sformatf("mul16_%0d result", k), 64'(bus16.result), 64'(e16[k]));
      check($sformatf("mul16_%0d tag", k), 64'(bus16.tag_out), 64'(k + 4));
      bus16.out_ready = 1'b1;
      @(posedge clk); #1;
      bus16.out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
